// File: rtl/overload_frame_tx.sv
// rtl/overload_frame_tx.sv - CAN overload frame transmitter driven by the interframe-space detector
//
// Sends a FLAG_BITS-long dominant overload flag, waits out any flag
// superposition from other nodes, then checks a DELIM_BITS-long recessive
// delimiter. At most MAX_OVERLOADS frames are sent between isStart pulses.
//
// Optional feature macro: OVERLOAD_STUCK_DETECT_EN
//   defined   - WAIT_REC gives up after MAX_SUPERPOS dominant bits (stuckError)
//   undefined - WAIT_REC waits for a recessive bit indefinitely, stuckError = 0
//
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   synchronous active-high reset
//   samplePoint  in   one-clk strobe per bit time at the sample point
//   canRX        in   bus level (1 = recessive)
//   isOverload   in   overload request from the interframe-space detector
//   isStart      in   start of frame; clears the overload counter
//   canTX        out  transmit level (1 = recessive)
//   endOverload  out  high for one bit time after the delimiter completes
//   busy         out  high while a frame is in progress
//   bitError     out  one-clk pulse: flag bit read back recessive
//   formError    out  one-clk pulse: dominant bit inside the delimiter
//   stuckError   out  one-clk pulse: too many dominant bits after the flag

module overload_frame_tx #(
    parameter int unsigned FLAG_BITS     = 6,
    parameter int unsigned DELIM_BITS    = 8,
    parameter int unsigned MAX_OVERLOADS = 2,
    parameter int unsigned MAX_SUPERPOS  = 14
) (
    input  logic clk,
    input  logic rst,
    input  logic samplePoint,
    input  logic canRX,
    input  logic isOverload,
    input  logic isStart,
    output logic canTX,
    output logic endOverload,
    output logic busy,
    output logic bitError,
    output logic formError,
    output logic stuckError
);

    localparam int unsigned BIT_W = $clog2(DELIM_BITS + 1);
    localparam logic [BIT_W-1:0] FLAG_LAST  = BIT_W'(FLAG_BITS);
    localparam logic [BIT_W-1:0] DELIM_LAST = BIT_W'(DELIM_BITS);
    localparam logic [BIT_W-1:0] BIT_ONE    = BIT_W'(1);
    localparam logic [1:0]       OVL_MAX    = 2'(MAX_OVERLOADS);

    // The flag is counted in the same counter as the delimiter, and the
    // overload counter is two bits wide.
    if (FLAG_BITS < 1 || FLAG_BITS > DELIM_BITS || DELIM_BITS < 1 ||
        MAX_OVERLOADS < 1 || MAX_OVERLOADS > 3 || MAX_SUPERPOS < 1) begin : g_param_check
        $error("overload_frame_tx: unsupported parameter combination");
    end

    typedef enum logic [1:0] {
        IDLE,
        FLAG,
        WAIT_REC,
        DELIM
    } state_t;

    state_t           state;
    logic [BIT_W-1:0] bit_cnt;
    logic [BIT_W-1:0] bit_cnt_inc;
    logic [1:0]       ovl_cnt;
    logic             delim_done;

    assign bit_cnt_inc = bit_cnt + BIT_ONE;

    // Strobe on which the last delimiter bit is sampled recessive. With a
    // one-bit delimiter the first recessive bit in WAIT_REC already ends it.
    always_comb begin
        delim_done = 1'b0;
        if (samplePoint && canRX) begin
            if (state == WAIT_REC) begin
                delim_done = (DELIM_LAST == BIT_ONE);
            end else if (state == DELIM) begin
                delim_done = (bit_cnt_inc == DELIM_LAST);
            end
        end
    end

`ifdef OVERLOAD_STUCK_DETECT_EN
    localparam int unsigned DOM_W = $clog2(MAX_SUPERPOS + 1);
    localparam logic [DOM_W-1:0] DOM_LAST = DOM_W'(MAX_SUPERPOS);
    localparam logic [DOM_W-1:0] DOM_ONE  = DOM_W'(1);

    logic [DOM_W-1:0] dom_cnt;
    logic [DOM_W-1:0] dom_cnt_inc;

    assign dom_cnt_inc = dom_cnt + DOM_ONE;
`else
    assign stuckError = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            canTX       <= 1'b1;
            endOverload <= 1'b0;
            busy        <= 1'b0;
            bitError    <= 1'b0;
            formError   <= 1'b0;
            bit_cnt     <= '0;
            ovl_cnt     <= 2'd0;
`ifdef OVERLOAD_STUCK_DETECT_EN
            stuckError  <= 1'b0;
            dom_cnt     <= '0;
`endif
        end else begin
            bitError  <= 1'b0;
            formError <= 1'b0;
`ifdef OVERLOAD_STUCK_DETECT_EN
            stuckError <= 1'b0;
`endif
            if (samplePoint) begin
                // endOverload only ever rises in IDLE, so every strobe
                // clears it; a request on that strobe is still accepted.
                endOverload <= 1'b0;
                unique case (state)
                    IDLE: begin
                        canTX <= 1'b1;
                        if (isOverload && (ovl_cnt < OVL_MAX)) begin
                            state   <= FLAG;
                            busy    <= 1'b1;
                            canTX   <= 1'b0;
                            bit_cnt <= '0;
                        end
                    end
                    FLAG: begin
                        if (canRX) begin
                            bitError <= 1'b1;
                            canTX    <= 1'b1;
                            busy     <= 1'b0;
                            state    <= IDLE;
                        end else begin
                            bit_cnt <= bit_cnt_inc;
                            if (bit_cnt_inc == FLAG_LAST) begin
                                canTX <= 1'b1;
                                state <= WAIT_REC;
`ifdef OVERLOAD_STUCK_DETECT_EN
                                dom_cnt <= '0;
`endif
                            end
                        end
                    end
                    WAIT_REC: begin
                        canTX <= 1'b1;
                        if (canRX) begin
                            // First recessive bit is delimiter bit 1.
                            bit_cnt <= BIT_ONE;
                            if (delim_done) begin
                                endOverload <= 1'b1;
                                busy        <= 1'b0;
                                state       <= IDLE;
                            end else begin
                                state <= DELIM;
                            end
                        end else begin
`ifdef OVERLOAD_STUCK_DETECT_EN
                            if (dom_cnt_inc == DOM_LAST) begin
                                stuckError <= 1'b1;
                                busy       <= 1'b0;
                                state      <= IDLE;
                            end
                            if (dom_cnt < DOM_LAST) begin
                                dom_cnt <= dom_cnt_inc;
                            end
`endif
                        end
                    end
                    DELIM: begin
                        canTX <= 1'b1;
                        if (!canRX) begin
                            formError <= 1'b1;
                            busy      <= 1'b0;
                            state     <= IDLE;
                        end else begin
                            bit_cnt <= bit_cnt_inc;
                            if (delim_done) begin
                                endOverload <= 1'b1;
                                busy        <= 1'b0;
                                state       <= IDLE;
                            end
                        end
                    end
                    default: begin
                        canTX <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                endcase
            end

            // isStart is checked last so it wins over a completing frame.
            if (isStart) begin
                ovl_cnt <= 2'd0;
            end else if (delim_done && (ovl_cnt < OVL_MAX)) begin
                ovl_cnt <= ovl_cnt + 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_overload_frame_tx.sv
// tb/tb_overload_frame_tx.sv - self-checking bench for overload_frame_tx
module tb_overload_frame_tx;

    logic clk = 1'b0;
    logic rst;
    logic samplePoint;
    logic canRX;
    logic isOverload;
    logic isStart;
    logic canTX;
    logic endOverload;
    logic busy;
    logic bitError;
    logic formError;
    logic stuckError;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    overload_frame_tx #(
        .FLAG_BITS    (6),
        .DELIM_BITS   (8),
        .MAX_OVERLOADS(2),
        .MAX_SUPERPOS (14)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .samplePoint(samplePoint),
        .canRX      (canRX),
        .isOverload (isOverload),
        .isStart    (isStart),
        .canTX      (canTX),
        .endOverload(endOverload),
        .busy       (busy),
        .bitError   (bitError),
        .formError  (formError),
        .stuckError (stuckError)
    );

    typedef struct {
        logic ovl;
        logic st;
        logic rx;
        logic tx;
        logic bsy;
        logic eo;
        logic be;
        logic fe;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic ovl, input logic st, input logic rx,
                                input logic tx, input logic bsy, input logic eo,
                                input logic be, input logic fe);
        vec_t v;
        v.ovl = ovl; v.st = st; v.rx = rx;
        v.tx = tx; v.bsy = bsy; v.eo = eo; v.be = be; v.fe = fe;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // One bit time: strobe with the given inputs, check outputs just after
    // the strobe edge, then one clk later check pulses ended and endOverload held.
    task automatic strobe(input logic ovl, input logic st, input logic rx,
                          input logic etx, input logic ebsy, input logic eeo,
                          input logic ebe, input logic efe, input logic ese,
                          input string tag);
        @(negedge clk);
        isOverload  = ovl;
        isStart     = st;
        canRX       = rx;
        samplePoint = 1'b1;
        @(posedge clk);
        #1;
        chk({tag, " canTX"}, canTX, etx);
        chk({tag, " busy"}, busy, ebsy);
        chk({tag, " endOverload"}, endOverload, eeo);
        chk({tag, " bitError"}, bitError, ebe);
        chk({tag, " formError"}, formError, efe);
        chk({tag, " stuckError"}, stuckError, ese);
        @(negedge clk);
        samplePoint = 1'b0;
        isOverload  = 1'b0;
        isStart     = 1'b0;
        @(posedge clk);
        #1;
        chk({tag, " pulse_one_clk"}, bitError | formError | stuckError, 1'b0);
        chk({tag, " eo_hold"}, endOverload, eeo);
        chk({tag, " tx_hold"}, canTX, etx);
    endtask

    task automatic full_frame(input int extra, input logic st_end, input string tag);
        strobe(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, {tag, " req"});
        for (int i = 1; i <= 6; i++)
            strobe(1'b0, 1'b0, 1'b0, logic'(i == 6), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                   $sformatf("%s flag%0d", tag, i));
        for (int i = 0; i < extra; i++)
            strobe(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                   $sformatf("%s superpos%0d", tag, i));
        for (int i = 1; i <= 8; i++)
            strobe(1'b0, (i == 8) ? st_end : 1'b0, 1'b1, 1'b1, logic'(i != 8),
                   logic'(i == 8), 1'b0, 1'b0, 1'b0, $sformatf("%s delim%0d", tag, i));
    endtask

    task automatic refuse(input string tag);
        strobe(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, tag);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; samplePoint = 1'b0; canRX = 1'b1; isOverload = 1'b0; isStart = 1'b0;

        // Basic frame with isStart pulsed mid-flag (must not abort).
        add(1, 0, 1, 0, 1, 0, 0, 0);
        for (int i = 1; i <= 6; i++) add(0, logic'(i == 3), 0, logic'(i == 6), 1, 0, 0, 0);
        for (int i = 1; i <= 7; i++) add(0, 0, 1, 1, 1, 0, 0, 0);
        add(0, 0, 1, 1, 0, 1, 0, 0);
        // Superposition frame: 5 extra dominant bits, 19 strobes to end.
        add(1, 0, 1, 0, 1, 0, 0, 0);
        for (int i = 1; i <= 6; i++) add(0, 0, 0, logic'(i == 6), 1, 0, 0, 0);
        for (int i = 1; i <= 5; i++) add(0, 0, 0, 1, 1, 0, 0, 0);
        for (int i = 1; i <= 7; i++) add(0, 0, 1, 1, 1, 0, 0, 0);
        add(0, 0, 1, 1, 0, 1, 0, 0);
        // Third request refused, isStart, then accepted.
        add(1, 0, 1, 1, 0, 0, 0, 0);
        add(0, 1, 1, 1, 0, 0, 0, 0);
        add(1, 0, 1, 0, 1, 0, 0, 0);

        repeat (3) @(posedge clk);
        #1;
        chk("reset canTX", canTX, 1'b1);
        chk("reset busy", busy, 1'b0);
        chk("reset endOverload", endOverload, 1'b0);
        chk("reset errors", bitError | formError | stuckError, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++)
            strobe(vecs[i].ovl, vecs[i].st, vecs[i].rx, vecs[i].tx, vecs[i].bsy,
                   vecs[i].eo, vecs[i].be, vecs[i].fe, 1'b0, $sformatf("vec%0d", i));

        // Bit error on flag bit 3 of the frame accepted above.
        strobe(0, 0, 0, 0, 1, 0, 0, 0, 0, "berr flag1");
        strobe(0, 0, 0, 0, 1, 0, 0, 0, 0, "berr flag2");
        strobe(0, 0, 1, 1, 0, 0, 1, 0, 0, "berr flag3");
        strobe(0, 0, 1, 1, 0, 0, 0, 0, 0, "berr idle");

        // Count is 0: one frame, a form-error frame (no count), one more
        // frame, then the limit must already be reached.
        full_frame(0, 1'b0, "f3");
        strobe(1, 0, 1, 0, 1, 0, 0, 0, 0, "ferr req");
        for (int i = 1; i <= 6; i++)
            strobe(0, 0, 0, logic'(i == 6), 1, 0, 0, 0, 0, $sformatf("ferr flag%0d", i));
        for (int i = 1; i <= 4; i++)
            strobe(0, 0, 1, 1, 1, 0, 0, 0, 0, $sformatf("ferr delim%0d", i));
        strobe(0, 0, 0, 1, 0, 0, 0, 1, 0, "ferr delim5");
        full_frame(0, 1'b0, "f4");
        refuse("limit after ferr");

        // isStart coinciding with a completing delimiter leaves the count at 0.
        strobe(0, 1, 1, 1, 0, 0, 0, 0, 0, "start");
        full_frame(0, 1'b0, "f5");
        full_frame(0, 1'b1, "f6 start_at_end");
        full_frame(0, 1'b0, "f7");
        full_frame(0, 1'b0, "f8");
        refuse("limit after coincide");

        // Reset mid-flag.
        strobe(0, 1, 1, 1, 0, 0, 0, 0, 0, "start2");
        strobe(1, 0, 1, 0, 1, 0, 0, 0, 0, "rst req");
        strobe(0, 0, 0, 0, 1, 0, 0, 0, 0, "rst flag1");
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midreset canTX", canTX, 1'b1);
        chk("midreset busy", busy, 1'b0);
        chk("midreset endOverload", endOverload, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Stuck bus after the flag.
        strobe(1, 0, 1, 0, 1, 0, 0, 0, 0, "stuck req");
        for (int i = 1; i <= 6; i++)
            strobe(0, 0, 0, logic'(i == 6), 1, 0, 0, 0, 0, $sformatf("stuck flag%0d", i));
`ifdef OVERLOAD_STUCK_DETECT_EN
        for (int i = 1; i <= 13; i++)
            strobe(0, 0, 0, 1, 1, 0, 0, 0, 0, $sformatf("stuck dom%0d", i));
        strobe(0, 0, 0, 1, 0, 0, 0, 0, 1, "stuck dom14");
        strobe(0, 0, 0, 1, 0, 0, 0, 0, 0, "stuck idle");
`else
        for (int i = 1; i <= 20; i++)
            strobe(0, 0, 0, 1, 1, 0, 0, 0, 0, $sformatf("stuck dom%0d", i));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/overload_frame_tx.md
# overload_frame_tx

Transmit-side companion of the interframe-space detector. When the detector flags an overload condition, this block drives a CAN overload frame onto `canTX`: a 6-bit dominant overload flag, a wait for the bus to return recessive, then an 8-bit recessive overload delimiter. On completion it returns `endOverload` to the detector, and it enforces the CAN limit of at most two consecutive overload frames between frame starts.

## Interface
- `FLAG_BITS`, default 6: dominant overload-flag length in bits.
- `DELIM_BITS`, default 8: overload-delimiter length in bits, including the first recessive bit seen after the flag.
- `MAX_OVERLOADS`, default 2: overload frames allowed between two `isStart` pulses.
- `MAX_SUPERPOS`, default 14: dominant bits tolerated after the flag before `stuckError` fires. Used only with `OVERLOAD_STUCK_DETECT_EN`.

Ports:
- `clk`  in  1: system clock. All logic is on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `samplePoint`  in  1: one-`clk` strobe per bit time, at the bit sample point.
- `canRX`  in  1: bus level (1 = recessive).
- `isOverload`  in  1: overload request from the interframe-space detector.
- `isStart`  in  1: start-of-frame indication. Clears the overload counter.
- `canTX`  out  1: transmit level. 1 = recessive.
- `endOverload`  out  1: high for exactly one bit time after the delimiter completes.
- `busy`  out  1: high whenever the state is not IDLE.
- `bitError`  out  1: one-`clk` pulse; flag bit read back recessive.
- `formError`  out  1: one-`clk` pulse; dominant bit sampled during the delimiter.
- `stuckError`  out  1: one-`clk` pulse; too many dominant bits after the flag.

## Operation
- State machine: IDLE, FLAG, WAIT_REC, DELIM. All transitions occur only on `clk` edges where `samplePoint` = 1.
- IDLE
  - `canTX` = 1.
  - If `isOverload` = 1 and `ovlCnt` < `MAX_OVERLOADS`: go to FLAG, set `canTX` <= 0, clear `bitCnt`.
  - If `isOverload` = 1 and `ovlCnt` = `MAX_OVERLOADS`: ignore the request and stay in IDLE.
- FLAG
  - Each strobe, check `canRX`. If 1: pulse `bitError`, set `canTX` <= 1, go to IDLE; `ovlCnt` is not incremented.
  - Otherwise increment `bitCnt`.
  - On the strobe that samples flag bit `FLAG_BITS`: set `canTX` <= 1, clear `domCnt`, go to WAIT_REC.
- WAIT_REC
  - `canTX` = 1.
  - `canRX` = 1: go to DELIM with `bitCnt` = 1. This bit counts as delimiter bit 1.
  - `canRX` = 0: increment `domCnt`. This is other nodes' flag superposition.
- DELIM
  - `canTX` = 1.
  - `canRX` = 0: pulse `formError`, go to IDLE, no increment.
  - `canRX` = 1: increment `bitCnt`.
  - At `bitCnt` = `DELIM_BITS`: go to IDLE, increment `ovlCnt`, set `endOverload` <= 1.
- `endOverload` clears at the next strobe, giving one bit time high. A new request can be accepted on that same strobe.
- `ovlCnt`
  - 2-bit counter, saturating at `MAX_OVERLOADS`.
  - Cleared when `isStart` = 1 on any `clk`.
  - If `isStart` and a completing delimiter coincide, the clear wins and `ovlCnt` = 0.
- `isStart` does not abort a transmission in progress.
- Counter widths:
  - `bitCnt` is `$clog2(DELIM_BITS+1)` bits.
  - `domCnt` is `$clog2(MAX_SUPERPOS+1)` bits and saturates; it never wraps.

## Timing
- Reset values: state IDLE, `canTX` = 1, `endOverload` = 0, `busy` = 0, all error pulses 0, `bitCnt` = 0, `domCnt` = 0, `ovlCnt` = 0.
- Reset mid-frame: `canTX` returns to 1 on the next `clk`. No `endOverload` is produced.
- Latency:
  - `canTX` goes dominant one `clk` after the request strobe, so the flag starts in the bit following the request.
  - All outputs are registered.
- Nominal frame, bus quiet after the flag: 6 dominant bits, then 8 recessive bits. `endOverload` rises one `clk` after the 14th strobe.
- Error pulses last exactly one `clk`, aligned with the strobe that detected the error.
- A `samplePoint` held high for several `clk` cycles is illegal. Only strobe edges advance the FSM.

## Configuration
- `OVERLOAD_STUCK_DETECT_EN` defined:
  - In WAIT_REC, when `domCnt` reaches `MAX_SUPERPOS`, pulse `stuckError` and go to IDLE.
  - `ovlCnt` is not incremented.
- Not defined:
  - WAIT_REC waits for a recessive bit indefinitely.
  - `stuckError` is tied to 0 and the `domCnt` logic is omitted.

## Test plan
- Basic frame: reset, then `isOverload` = 1 on one strobe with `canRX` mirroring `canTX`. Expect `canTX` = 0 for 6 strobes, then 1. `endOverload` is high for one bit after 14 strobes, `busy` low afterwards, `ovlCnt` = 1.
- Superposition: after the flag, hold `canRX` = 0 for 5 extra strobes, then release. Expect the delimiter to count 8 recessive bits from the release, and `endOverload` after 6 + 5 + 8 = 19 strobes.
- Limit: complete two frames, then request a third. Expect `canTX` to stay at 1 and `busy` = 0. Pulse `isStart`, request again, and expect a frame to be transmitted.
- Bit error: drive `canRX` = 1 at flag bit 3. Expect a `bitError` pulse, `canTX` = 1 on the next `clk`, state IDLE, no `endOverload`.
- Form error: drive `canRX` = 0 at delimiter bit 5. Expect a `formError` pulse, then IDLE with `ovlCnt` unchanged.
- Stuck bus, with `OVERLOAD_STUCK_DETECT_EN`: keep `canRX` = 0 after the flag. Expect a `stuckError` pulse on the 14th dominant strobe after the flag, then IDLE. Without the macro, expect `busy` to stay high.
